// File: rtl/fraction_accumulator_if.sv
// ============================================================================
// Module      : fraction_accumulator_if
// Description : Bundles the multiplier-side inputs (Clr, Done, Product) and the
//               sum-side outputs of fraction_accumulator. The master modport
//               drives terms in; the slave modport is the accumulator itself.
//               Frac_Out exists only when FRAC_ROUND_SAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fraction_accumulator_if #(
    parameter int PW    = 7,
    parameter int N     = 4,
    parameter int GUARD = 3
);
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(N);

    logic          Clr;
    logic          Done;
    logic [PW-1:0] Product;
    logic [AW-1:0] Sum;
    logic          Sum_Valid;
    logic [CW-1:0] Count;
    logic          Busy;
    logic          Overflow;
`ifdef FRAC_ROUND_SAT_EN
    logic [3:0]    Frac_Out;
`endif

    modport master (
        output Clr, Done, Product,
        input  Sum, Sum_Valid, Count, Busy, Overflow
`ifdef FRAC_ROUND_SAT_EN
        , input Frac_Out
`endif
    );

    modport slave (
        input  Clr, Done, Product,
        output Sum, Sum_Valid, Count, Busy, Overflow
`ifdef FRAC_ROUND_SAT_EN
        , output Frac_Out
`endif
    );
endinterface

`default_nettype wire

// File: rtl/fraction_accumulator.sv
// ============================================================================
// Module      : fraction_accumulator
// Description : Sums N consecutive Q1.6 products (one per Done rising edge)
//               into a guarded two's-complement accumulator and presents the
//               completed sum with a one-cycle Sum_Valid pulse. Sticky signed
//               overflow flag, synchronous Clr abort, async active-high RST.
//               Optional macro FRAC_ROUND_SAT_EN adds a rounded, saturated
//               Q1.3 copy of the sum on Frac_Out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fraction_accumulator #(
    parameter int PW    = 7,
    parameter int N     = 4,
    parameter int GUARD = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    fraction_accumulator_if.slave  bus
);
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic [CW-1:0] LAST_COUNT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    logic [0:0]    state;
    logic          done_d;
    logic [AW-1:0] acc;
    logic [CW-1:0] count;
    logic [AW-1:0] sum;
    logic          sum_valid;
    logic          overflow;

    logic          take;
    logic [AW-1:0] ext;
    logic [AW-1:0] add;
    logic          add_ovf;

    // Rising-edge detect on Done, sign extension of the term and the running add
    always_comb begin
        take    = bus.Done & ~done_d;
        ext     = {{GUARD{bus.Product[PW-1]}}, bus.Product};
        add     = acc + ext;
        // Signed overflow: operands agree in sign but the result does not
        add_ovf = (acc[AW-1] == ext[AW-1]) && (add[AW-1] != acc[AW-1]);
    end

`ifdef FRAC_ROUND_SAT_EN
    logic signed [AW:0] rnd;
    logic signed [AW:0] shr;
    logic [3:0]         frac_next;
    logic [3:0]         frac_q;

    // Round half up from Q.6 to Q.3 and clamp to the 4-bit Q1.3 range
    always_comb begin
        rnd = $signed({add[AW-1], add}) + $signed((AW+1)'(4));
        shr = rnd >>> 3;
        if (shr > 7) begin
            frac_next = 4'b0111;
        end else if (shr < -8) begin
            frac_next = 4'b1000;
        end else begin
            frac_next = shr[3:0];
        end
    end

    // Rounded copy follows Sum, updated only on a completed sum
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frac_q <= 4'b0000;
        end else if (!bus.Clr && take && state == ACCUM && count == LAST_COUNT) begin
            frac_q <= frac_next;
        end
    end

    assign bus.Frac_Out = frac_q;
`endif

    // Term sequencer: first term loads, middle terms add, last term publishes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            done_d    <= 1'b0;
            acc       <= '0;
            count     <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done_d    <= bus.Done;
            sum_valid <= 1'b0;
            if (bus.Clr) begin
                // Abort discards the partial sum; a coincident term starts afresh
                overflow <= 1'b0;
                if (take) begin
                    acc   <= ext;
                    count <= ONE_COUNT;
                    state <= ACCUM;
                end else begin
                    acc   <= '0;
                    count <= '0;
                    state <= IDLE;
                end
            end else if (take) begin
                if (state == IDLE) begin
                    acc   <= ext;
                    count <= ONE_COUNT;
                    state <= ACCUM;
                end else begin
                    if (add_ovf) begin
                        overflow <= 1'b1;
                    end
                    if (count == LAST_COUNT) begin
                        sum       <= add;
                        sum_valid <= 1'b1;
                        acc       <= '0;
                        count     <= '0;
                        state     <= IDLE;
                    end else begin
                        acc   <= add;
                        count <= count + ONE_COUNT;
                    end
                end
            end
        end
    end

    assign bus.Sum       = sum;
    assign bus.Sum_Valid = sum_valid;
    assign bus.Count     = count;
    assign bus.Busy      = (state == ACCUM);
    assign bus.Overflow  = overflow;

endmodule

`default_nettype wire

// File: tb/tb_fraction_accumulator.sv
// ============================================================================
// Module      : tb_fraction_accumulator
// Description : Self-checking bench for fraction_accumulator. A 4-term DUT
//               covers sums, Done edge handling, Clr and async reset; a
//               16-term DUT covers the sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fraction_accumulator;
    logic CLK;
    logic RST;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model for the 4-term DUT
    int         m_acc = 0;
    int         m_cnt = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_sum;
    logic [9:0] held_sum;

    fraction_accumulator_if #(.PW(7), .N(4),  .GUARD(3)) bus4 ();
    fraction_accumulator_if #(.PW(7), .N(16), .GUARD(3)) bus16 ();

    fraction_accumulator #(.PW(7), .N(4), .GUARD(3)) u_dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4)
    );

    fraction_accumulator #(.PW(7), .N(16), .GUARD(3)) u_dut16 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus16)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic m_clear();
        m_acc = 0;
        m_cnt = 0;
    endtask

    task automatic m_take(input logic [6:0] p);
        m_acc = m_acc + int'($signed(p));
        m_cnt = m_cnt + 1;
        if (m_cnt == 4) begin
            exp_q.push_back(10'(m_acc));
            m_clear();
        end
    endtask

    // Raise Done with a product, record it in the model, return just after the sampling edge
    task automatic rise(input logic [6:0] p);
        @(negedge CLK);
        bus4.Product = p;
        bus4.Done    = 1'b1;
        m_take(p);
        @(posedge CLK);
        #1;
    endtask

    task automatic fall();
        @(negedge CLK);
        bus4.Done = 1'b0;
    endtask

    task automatic pulse(input logic [6:0] p);
        rise(p);
        fall();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if (bus4.Sum !== 10'h000 || bus4.Sum_Valid !== 1'b0 || bus4.Count !== 2'd0 ||
            bus4.Busy !== 1'b0 || bus4.Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: Sum=%h Valid=%b Count=%0d Busy=%b Ovf=%b, expected all zero",
                     bus4.Sum, bus4.Sum_Valid, bus4.Count, bus4.Busy, bus4.Overflow);
        end
`ifdef FRAC_ROUND_SAT_EN
        vectors++;
        if (bus4.Frac_Out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_frac: got %b expected 0000", bus4.Frac_Out);
        end
`endif
        RST = 1'b0;
    endtask

    task automatic test_single_sum();
        for (int i = 1; i <= 3; i++) begin
            rise(7'h20);
            vectors++;
            if (bus4.Sum_Valid !== 1'b0 || bus4.Count !== 2'(i) || bus4.Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_partial%0d: Valid=%b Count=%0d Busy=%b, expected 0/%0d/1",
                         i, bus4.Sum_Valid, bus4.Count, bus4.Busy, i);
            end
            fall();
        end
        rise(7'h20);
        exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
        vectors++;
        if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum || bus4.Sum !== 10'h080) begin
            miscompares++;
            $display("FAIL single_sum: Valid=%b Sum=%h, expected 1/%h (080)", bus4.Sum_Valid, bus4.Sum, exp_sum);
        end
        vectors++;
        if (bus4.Count !== 2'd0 || bus4.Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count_ret: Count=%0d Busy=%b, expected 0/0", bus4.Count, bus4.Busy);
        end
`ifdef FRAC_ROUND_SAT_EN
        vectors++;
        if (bus4.Frac_Out !== 4'b0111) begin
            miscompares++;
            $display("FAIL single_frac_sat: got %b expected 0111", bus4.Frac_Out);
        end
`endif
        fall();
        @(posedge CLK);
        #1;
        vectors++;
        if (bus4.Sum_Valid !== 1'b0 || bus4.Sum !== 10'h080) begin
            miscompares++;
            $display("FAIL single_pulse_width: Valid=%b Sum=%h, expected 0/080", bus4.Sum_Valid, bus4.Sum);
        end
    endtask

    task automatic test_mixed();
        pulse(7'h20);
        pulse(7'h60);
        pulse(7'h10);
        rise(7'h08);
        exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
        vectors++;
        if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum || bus4.Sum !== 10'h018 ||
            bus4.Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL mixed_sum: Valid=%b Sum=%h Ovf=%b, expected 1/%h (018)/0",
                     bus4.Sum_Valid, bus4.Sum, bus4.Overflow, exp_sum);
        end
`ifdef FRAC_ROUND_SAT_EN
        vectors++;
        if (bus4.Frac_Out !== 4'b0011) begin
            miscompares++;
            $display("FAIL mixed_frac: got %b expected 0011", bus4.Frac_Out);
        end
`endif
        fall();
    endtask

    task automatic test_held_done();
        rise(7'h10);
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK);
            #1;
            vectors++;
            if (bus4.Count !== 2'd1) begin
                miscompares++;
                $display("FAIL held_count%0d: got %0d expected 1", k, bus4.Count);
            end
        end
        fall();
        pulse(7'h10);
        pulse(7'h10);
        rise(7'h10);
        exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
        vectors++;
        if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum || bus4.Sum !== 10'h040) begin
            miscompares++;
            $display("FAIL held_sum: Valid=%b Sum=%h, expected 1/%h (040)", bus4.Sum_Valid, bus4.Sum, exp_sum);
        end
        fall();
    endtask

    task automatic test_clear();
        held_sum = 10'h040;
        pulse(7'h20);
        pulse(7'h20);
        @(negedge CLK);
        bus4.Clr = 1'b1;
        m_clear();
        @(posedge CLK);
        #1;
        vectors++;
        if (bus4.Count !== 2'd0 || bus4.Busy !== 1'b0 || bus4.Sum !== held_sum || bus4.Sum_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_alone: Count=%0d Busy=%b Sum=%h Valid=%b, expected 0/0/%h/0",
                     bus4.Count, bus4.Busy, bus4.Sum, bus4.Sum_Valid, held_sum);
        end
        @(negedge CLK);
        bus4.Clr = 1'b0;
        for (int i = 0; i < 3; i++) pulse(7'h08);
        rise(7'h08);
        exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
        vectors++;
        if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum || bus4.Sum !== 10'h020) begin
            miscompares++;
            $display("FAIL clear_resum: Valid=%b Sum=%h, expected 1/%h (020)", bus4.Sum_Valid, bus4.Sum, exp_sum);
        end
        fall();
    endtask

    task automatic test_clr_with_take();
        pulse(7'h10);
        @(negedge CLK);
        bus4.Clr     = 1'b1;
        bus4.Product = 7'h20;
        bus4.Done    = 1'b1;
        m_clear();
        m_take(7'h20);
        @(posedge CLK);
        #1;
        vectors++;
        if (bus4.Count !== 2'd1 || bus4.Busy !== 1'b1 || u_dut4.acc !== 10'h020 || bus4.Sum_Valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_take: Count=%0d Busy=%b Acc=%h Valid=%b, expected 1/1/020/0",
                     bus4.Count, bus4.Busy, u_dut4.acc, bus4.Sum_Valid);
        end
        @(negedge CLK);
        bus4.Clr  = 1'b0;
        bus4.Done = 1'b0;
        pulse(7'h20);
        pulse(7'h20);
        rise(7'h20);
        exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
        vectors++;
        if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum || bus4.Sum !== 10'h080) begin
            miscompares++;
            $display("FAIL clr_take_sum: Valid=%b Sum=%h, expected 1/%h (080)", bus4.Sum_Valid, bus4.Sum, exp_sum);
        end
        fall();
    endtask

    task automatic test_back_to_back();
        logic [6:0] vals [8];
        vals = '{7'h08, 7'h08, 7'h08, 7'h08, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        for (int i = 0; i < 8; i++) begin
            rise(vals[i]);
            if (i == 3 || i == 7) begin
                exp_sum = exp_q.size() > 0 ? exp_q.pop_front() : 10'h3FF;
                vectors++;
                if (bus4.Sum_Valid !== 1'b1 || bus4.Sum !== exp_sum) begin
                    miscompares++;
                    $display("FAIL b2b_sum%0d: Valid=%b Sum=%h, expected 1/%h", i, bus4.Sum_Valid, bus4.Sum, exp_sum);
                end
            end
            if (i == 4) begin
                vectors++;
                if (bus4.Sum_Valid !== 1'b0 || bus4.Count !== 2'd1 || bus4.Sum !== 10'h020) begin
                    miscompares++;
                    $display("FAIL b2b_restart: Valid=%b Count=%0d Sum=%h, expected 0/1/020",
                             bus4.Sum_Valid, bus4.Count, bus4.Sum);
                end
            end
            fall();
        end
        vectors++;
        if (bus4.Sum !== 10'h0FC) begin
            miscompares++;
            $display("FAIL b2b_final: Sum=%h expected 0FC", bus4.Sum);
        end
    endtask

    task automatic test_async_reset();
        pulse(7'h20);
        pulse(7'h20);
        vectors++;
        if (bus4.Count !== 2'd2) begin
            miscompares++;
            $display("FAIL async_pre: Count=%0d expected 2", bus4.Count);
        end
        #2;
        RST = 1'b1;
        #1;
        vectors++;
        if (bus4.Sum !== 10'h000 || bus4.Count !== 2'd0 || bus4.Busy !== 1'b0 ||
            bus4.Sum_Valid !== 1'b0 || bus4.Overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: Sum=%h Count=%0d Busy=%b Valid=%b Ovf=%b, expected all zero",
                     bus4.Sum, bus4.Count, bus4.Busy, bus4.Sum_Valid, bus4.Overflow);
        end
        @(negedge CLK);
        RST = 1'b0;
        m_clear();
        exp_q.delete();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK);
            bus16.Product = 7'h40;
            bus16.Done    = 1'b1;
            @(posedge CLK);
            #1;
            if (i == 8 || i == 9 || i == 12) begin
                vectors++;
                if (bus16.Overflow !== (i >= 9) || bus16.Count !== 4'(i)) begin
                    miscompares++;
                    $display("FAIL overflow_term%0d: Ovf=%b Count=%0d, expected %b/%0d",
                             i, bus16.Overflow, bus16.Count, (i >= 9), i);
                end
            end
            @(negedge CLK);
            bus16.Done = 1'b0;
        end
        @(negedge CLK);
        bus16.Clr = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if (bus16.Overflow !== 1'b0 || bus16.Count !== 4'd0) begin
            miscompares++;
            $display("FAIL overflow_clr: Ovf=%b Count=%0d, expected 0/0", bus16.Overflow, bus16.Count);
        end
        @(negedge CLK);
        bus16.Clr = 1'b0;
    endtask

    initial begin
        RST           = 1'b1;
        bus4.Clr      = 1'b0;
        bus4.Done     = 1'b0;
        bus4.Product  = '0;
        bus16.Clr     = 1'b0;
        bus16.Done    = 1'b0;
        bus16.Product = '0;
        test_reset();
        test_single_sum();
        test_mixed();
        test_held_done();
        test_clear();
        test_clr_with_take();
        test_back_to_back();
        test_async_reset();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
